// File: rtl/secure_storage_reader.sv
// -----------------------------------------------------------------------------
// secure_storage_reader
//
// Read-side initiator for the secure storage array. A burst command walks the
// storage's combinational read port one word per beat and streams the words
// out on a valid/ready interface. Words in the protected upper region are only
// returned while the key-based unlock is active; otherwise the beat carries
// zero data, is flagged with rd_err, and the sticky violation flag is raised.
// Repeated bad keys lock the unlock path out until reset.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               burst command strobe (ignored while busy)
//   base_addr, count    first word address, word count (0..256, 0 = empty)
//   mem_addr            address to storage read port
//   mem_rdata           storage read data (combinational from mem_addr)
//   rd_data, rd_valid   streamed word and its valid
//   rd_ready            downstream accept
//   rd_last, rd_err     final beat / blocked beat, qualified by rd_valid
//   busy, done          burst in progress / one-cycle completion pulse
//   unlock_req, key_in  unlock attempt strobe and candidate key
//   lock_req            drop unlock
//   unlocked, lockout   protected region readable / unlock disabled
//   violation           sticky: a blocked beat has been produced
// -----------------------------------------------------------------------------
module secure_storage_reader #(
  parameter logic [7:0]  PROT_BASE = 8'hC0,
  parameter logic [31:0] KEY       = 32'hA5C3_5A3C,
  parameter int unsigned MAX_FAILS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic [8:0]  count,
  output logic [7:0]  mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  output logic        rd_err,
  output logic        busy,
  output logic        done,
  input  logic        unlock_req,
  input  logic [31:0] key_in,
  input  logic        lock_req,
  output logic        unlocked,
  output logic        lockout,
  output logic        violation
);

  localparam logic [3:0] MAX_FAILS_W = 4'(MAX_FAILS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  addr_q;
  logic [8:0]  rem_q;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;
  logic        rd_last_q;
  logic        rd_err_q;
  logic        busy_q;
  logic        done_q;
  logic        violation_q;

  logic        unlocked_q, unlocked_d;
  logic        lockout_q,  lockout_d;
  logic [3:0]  fails_q,    fails_d;

  logic        blocked;

  // Protection decision uses the registered unlock state, so a lock/unlock
  // strobe only affects fetches from the following edge onward.
  assign blocked = (addr_q >= PROT_BASE) && !unlocked_q;

  // ---------------------------------------------------------------------------
  // Unlock / lockout next state (independent of the burst FSM)
  // ---------------------------------------------------------------------------
  always_comb begin
    unlocked_d = unlocked_q;
    lockout_d  = lockout_q;
    fails_d    = fails_q;
    if (unlock_req && !lockout_q) begin
      if (key_in == KEY) begin
        unlocked_d = 1'b1;
        fails_d    = 4'd0;
      end else begin
        fails_d = fails_q + 4'd1;
        if (fails_d == MAX_FAILS_W) begin
          lockout_d  = 1'b1;
          unlocked_d = 1'b0;
        end
      end
    end
    // lock_req has priority over a simultaneous successful unlock; the
    // mismatch counter above still updates.
    if (lock_req) begin
      unlocked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      fails_q    <= 4'd0;
    end else begin
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
      fails_q    <= fails_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst FSM: FETCH samples the read port, SEND holds the beat until accepted
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 8'd0;
      rem_q       <= 9'd0;
      rd_data_q   <= 32'd0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      violation_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            rem_q  <= count;
            if (count == 9'd0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= FETCH;
            end
          end
        end

        FETCH: begin
          if (blocked) begin
            rd_data_q   <= 32'd0;
            rd_err_q    <= 1'b1;
            violation_q <= 1'b1;
          end else begin
            rd_data_q <= mem_rdata;
            rd_err_q  <= 1'b0;
          end
          rd_last_q  <= (rem_q == 9'd1);
          rd_valid_q <= 1'b1;
          state_q    <= SEND;
        end

        SEND: begin
          if (rd_ready) begin
            rd_valid_q <= 1'b0;
            if (rd_last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              addr_q  <= addr_q + 8'd1;   // 8-bit wrap FF -> 00 is intended
              rem_q   <= rem_q - 9'd1;
              state_q <= FETCH;
            end
          end
        end

        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          rd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_err    = rd_err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign unlocked  = unlocked_q;
  assign lockout   = lockout_q;
  assign violation = violation_q;

endmodule

// File: tb/tb_secure_storage_reader.sv
module tb_secure_storage_reader;

  localparam logic [31:0] GOOD_KEY = 32'hA5C3_5A3C;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic        rd_err;
  logic        busy;
  logic        done;
  logic        unlock_req;
  logic [31:0] key_in;
  logic        lock_req;
  logic        unlocked;
  logic        lockout;
  logic        violation;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr];

  secure_storage_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_last    (rd_last),
    .rd_err     (rd_err),
    .busy       (busy),
    .done       (done),
    .unlock_req (unlock_req),
    .key_in     (key_in),
    .lock_req   (lock_req),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .violation  (violation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Beats captured by the collector
  logic [31:0] bd [0:15];
  logic        be [0:15];
  logic        bl [0:15];
  logic [7:0]  ba [0:15];
  int          nbeats;
  int          done_cyc;
  int          first_vld;
  bit          saw_valid;
  bit          timeout;
  logic        busy0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples from the current point (1 time unit after an edge); cyc counts
  // edges since the start edge. Stops when done is seen.
  task automatic collect(input int cyc_start, input int budget);
    int cyc;
    cyc      = cyc_start;
    done_cyc = -1;
    timeout  = 1'b1;
    while (cyc < budget) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        timeout  = 1'b0;
        break;
      end
      if (rd_valid === 1'b1) begin
        saw_valid = 1'b1;
        if (first_vld < 0) first_vld = cyc;
        if (rd_ready) begin
          if (nbeats < 16) begin
            bd[nbeats] = rd_data;
            be[nbeats] = rd_err;
            bl[nbeats] = rd_last;
            ba[nbeats] = mem_addr;
          end
          nbeats++;
        end
      end
      tick();
      cyc++;
    end
  endtask

  task automatic start_burst(input logic [7:0] b, input logic [8:0] n);
    nbeats    = 0;
    saw_valid = 1'b0;
    first_vld = -1;
    start     = 1'b1;
    base_addr = b;
    count     = n;
    tick();
    start = 1'b0;
    busy0 = busy;
  endtask

  task automatic run_burst(input logic [7:0] b, input logic [8:0] n);
    start_burst(b, n);
    collect(0, 600);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({rd_data, rd_valid, rd_last, rd_err, busy, done, mem_addr, unlocked, lockout, violation}
        !== 49'd0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%h vld=%b last=%b err=%b busy=%b done=%b addr=%h unl=%b lko=%b vio=%b required all zero",
               rd_data, rd_valid, rd_last, rd_err, busy, done, mem_addr, unlocked, lockout, violation);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_open_burst();
    run_burst(8'h10, 9'd4);
    checks++;
    if (timeout || done_cyc != 8) begin
      failures++;
      $display("FAIL open_done_cycle: got %0d (timeout=%0d) required 8", done_cyc, timeout);
    end
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("FAIL open_busy_after_start: got %b required 1", busy0);
    end
    checks++;
    if (first_vld != 1) begin
      failures++;
      $display("FAIL open_first_valid: got cycle %0d required 1", first_vld);
    end
    checks++;
    if (nbeats != 4) begin
      failures++;
      $display("FAIL open_beats: got %0d required 4", nbeats);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bd[i] !== (32'h1111_0010 + 32'(i)) || be[i] !== 1'b0 || bl[i] !== (i == 3)) begin
        failures++;
        $display("FAIL open_beat%0d: got data=%h err=%b last=%b required data=%h err=0 last=%0d",
                 i, bd[i], be[i], bl[i], 32'h1111_0010 + 32'(i), (i == 3));
      end
    end
    checks++;
    if (busy !== 1'b0 || violation !== 1'b0) begin
      failures++;
      $display("FAIL open_after_done: got busy=%b violation=%b required 0 0", busy, violation);
    end
  endtask

  task automatic test_protected();
    run_burst(8'hBF, 9'd3);
    checks++;
    if (timeout || nbeats != 3) begin
      failures++;
      $display("FAIL prot_beats: got %0d (timeout=%0d) required 3", nbeats, timeout);
    end
    checks++;
    if (bd[0] !== 32'h1111_00BF || be[0] !== 1'b0) begin
      failures++;
      $display("FAIL prot_beat0: got data=%h err=%b required 111100bf 0", bd[0], be[0]);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (bd[i] !== 32'd0 || be[i] !== 1'b1 || bl[i] !== (i == 2)) begin
        failures++;
        $display("FAIL prot_beat%0d: got data=%h err=%b last=%b required 0 1 %0d",
                 i, bd[i], be[i], bl[i], (i == 2));
      end
    end
    tick();
    tick();
    tick();
    checks++;
    if (violation !== 1'b1) begin
      failures++;
      $display("FAIL prot_violation_sticky: got %b required 1", violation);
    end
  endtask

  task automatic test_unlock_wrap();
    unlock_req = 1'b1;
    key_in     = GOOD_KEY;
    tick();
    unlock_req = 1'b0;
    key_in     = 32'd0;
    checks++;
    if (unlocked !== 1'b1) begin
      failures++;
      $display("FAIL unlock_good_key: got %b required 1", unlocked);
    end
    run_burst(8'hFE, 9'd4);
    checks++;
    if (timeout || nbeats != 4) begin
      failures++;
      $display("FAIL wrap_beats: got %0d (timeout=%0d) required 4", nbeats, timeout);
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ea;
      ea = 8'hFE + 8'(i);
      checks++;
      if (ba[i] !== ea || bd[i] !== (32'h1111_0000 + 32'(ea)) || be[i] !== 1'b0) begin
        failures++;
        $display("FAIL wrap_beat%0d: got addr=%h data=%h err=%b required addr=%h data=%h err=0",
                 i, ba[i], bd[i], be[i], ea, 32'h1111_0000 + 32'(ea));
      end
    end
  endtask

  task automatic test_lockout();
    for (int i = 0; i < 3; i++) begin
      unlock_req = 1'b1;
      key_in     = 32'd0;
      tick();
      unlock_req = 1'b0;
      checks++;
      if (lockout !== (i == 2)) begin
        failures++;
        $display("FAIL lockout_after_bad%0d: got %b required %0d", i + 1, lockout, (i == 2));
      end
    end
    checks++;
    if (unlocked !== 1'b0) begin
      failures++;
      $display("FAIL lockout_clears_unlock: got %b required 0", unlocked);
    end
    unlock_req = 1'b1;
    key_in     = GOOD_KEY;
    tick();
    unlock_req = 1'b0;
    checks++;
    if (unlocked !== 1'b0 || lockout !== 1'b1) begin
      failures++;
      $display("FAIL lockout_good_key_ignored: got unlocked=%b lockout=%b required 0 1", unlocked, lockout);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (lockout !== 1'b0 || violation !== 1'b0) begin
      failures++;
      $display("FAIL lockout_rst_clear: got lockout=%b violation=%b required 0 0", lockout, violation);
    end
    unlock_req = 1'b1;
    key_in     = GOOD_KEY;
    tick();
    unlock_req = 1'b0;
    checks++;
    if (unlocked !== 1'b1) begin
      failures++;
      $display("FAIL lockout_unlock_after_rst: got %b required 1", unlocked);
    end
  endtask

  task automatic test_backpressure();
    rd_ready = 1'b0;
    start_burst(8'hC0, 9'd3);
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h1111_00C0 || rd_err !== 1'b0) begin
      failures++;
      $display("FAIL bp_beat0_present: got vld=%b data=%h err=%b required 1 111100c0 0",
               rd_valid, rd_data, rd_err);
    end
    for (int s = 0; s < 5; s++) begin
      if (s == 1) lock_req = 1'b1;
      tick();
      lock_req = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h1111_00C0 || rd_err !== 1'b0 || rd_last !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d: got vld=%b data=%h err=%b last=%b required 1 111100c0 0 0",
                 s, rd_valid, rd_data, rd_err, rd_last);
      end
    end
    checks++;
    if (unlocked !== 1'b0) begin
      failures++;
      $display("FAIL bp_lock_req: got unlocked=%b required 0", unlocked);
    end
    rd_ready = 1'b1;
    collect(7, 600);
    checks++;
    if (timeout || nbeats != 3) begin
      failures++;
      $display("FAIL bp_beats: got %0d (timeout=%0d) required 3", nbeats, timeout);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (bd[i] !== 32'd0 || be[i] !== 1'b1) begin
        failures++;
        $display("FAIL bp_blocked%0d: got data=%h err=%b required 0 1", i, bd[i], be[i]);
      end
    end
    checks++;
    if (violation !== 1'b1) begin
      failures++;
      $display("FAIL bp_violation: got %b required 1", violation);
    end
  endtask

  task automatic test_edge_cases();
    // Empty burst
    run_burst(8'h20, 9'd0);
    checks++;
    if (timeout || done_cyc != 0 || busy0 !== 1'b0 || saw_valid) begin
      failures++;
      $display("FAIL empty_burst: got done_cyc=%0d busy=%b saw_valid=%0d required 0 0 0",
               done_cyc, busy0, saw_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_pulse: got done=%b busy=%b vld=%b required 0 0 0", done, busy, rd_valid);
    end

    // start while busy is ignored
    rd_ready = 1'b0;
    start_burst(8'h10, 9'd2);
    start     = 1'b1;
    base_addr = 8'h40;
    count     = 9'd5;
    tick();
    tick();
    start    = 1'b0;
    rd_ready = 1'b1;
    collect(2, 600);
    checks++;
    if (timeout || nbeats != 2 || bd[0] !== 32'h1111_0010 || bd[1] !== 32'h1111_0011 || bl[1] !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_ignored: got beats=%0d d0=%h d1=%h last1=%b required 2 11110010 11110011 1",
               nbeats, bd[0], bd[1], bl[1]);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_not_queued: got busy=%b vld=%b required 0 0", busy, rd_valid);
    end

    // Reset in the middle of SEND
    rd_ready = 1'b0;
    start_burst(8'h10, 9'd3);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_data, rd_valid, rd_last, rd_err, busy, done, mem_addr, unlocked, lockout, violation}
        !== 49'd0) begin
      failures++;
      $display("FAIL rst_mid_send: got data=%h vld=%b last=%b err=%b busy=%b done=%b addr=%h unl=%b lko=%b vio=%b required all zero",
               rd_data, rd_valid, rd_last, rd_err, busy, done, mem_addr, unlocked, lockout, violation);
    end
    tick();
    rst      = 1'b0;
    rd_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || rd_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      failures++;
      $display("FAIL rst_no_done: got done or rd_valid after abort, required none");
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = 8'd0;
    count      = 9'd0;
    rd_ready   = 1'b1;
    unlock_req = 1'b0;
    key_in     = 32'd0;
    lock_req   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1111_0000 + 32'(i);
    #2;

    test_reset();
    test_open_burst();
    test_protected();
    test_unlock_wrap();
    test_lockout();
    test_backpressure();
    test_edge_cases();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
